inst_issue_ctrl: RTL
====================

Name: inst_issue_ctrl

Overview:
- Instruction issue controller in front of the processor datapath's `inst` port.
- Accepts 32-bit R-type instructions from an upstream source over a valid/ready handshake and buffers them in a small FIFO.
- Issues at most one instruction per cycle and checks opcode/funct3 legality.
- Inserts NOP bubbles (32'h0) when a source register depends on a destination still in flight through the regbank write path.

Parameters:
- DEPTH, 4: FIFO entries (power of two, ≥2).
- WB_LATENCY, 2: bubble cycles needed between a writer and a dependent reader (≥1).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream instruction valid.
- in_inst  in  32  {funct7, rs2, rs1, funct3, rd, opcode}.
- in_ready  out  1  FIFO can accept.
- halt  in  1  suppress issue (bubbles only).
- flush  in  1  discard FIFO and scoreboard.
- issue_inst  out  32  instruction to datapath; 32'h0 = NOP.
- issue_valid  out  1  issue_inst is a real instruction.
- illegal  out  1  one-cycle pulse: rejected instruction.
- count  out  $clog2(DEPTH+1)  FIFO occupancy.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (reset_n low at edge): FIFO empty, scoreboard cleared, issue_inst=0, issue_valid=0, illegal=0, count=0, state=IDLE. in_ready=0 while reset_n low, otherwise in_ready = (count != DEPTH).
- Legal set:
  - opcode 7'h01 with funct3 0–1 (ADD/SUB).
  - opcode 7'h03 with funct3 0–2 (SLL/SRL/SRA).
  - opcode 7'h07 with funct3 0–1 (SLT/SLTU).
  - opcode 7'h0f with funct3 0–2 (XOR/OR/AND).
  - funct7 is ignored.
- Accept: in_valid & in_ready at an edge.
  - Legal: push.
  - Illegal: no push; illegal=1 for the next cycle.
- No push when full, even if a pop happens in the same cycle; in_ready depends on registered count only.
- Scoreboard: WB_LATENCY slots {v, rd[4:0]}.
  - Every edge, slots shift toward slot[WB_LATENCY-1] and the oldest drops.
  - slot[0] loads {1, rd} on an issue edge, otherwise {0, x}.
- Hazard: head.rs1 or head.rs2 equals slot[i].rd for any valid slot i, with rd != 0.
- Issue condition at an edge: FIFO non-empty & !hazard & !halt & !flush. Then issue_inst <= head, issue_valid <= 1, pop. Otherwise issue_inst <= 0, issue_valid <= 0.
- Outputs are registered. An instruction accepted at edge E into an empty FIFO with no hazard appears on issue_inst after edge E+1; there is no bypass.
- Back-to-back dependent pair: exactly WB_LATENCY NOP cycles between them. Independent instructions issue on consecutive cycles.
- Simultaneous push and pop: count unchanged. Pointers wrap modulo DEPTH.
- flush, applied at that edge:
  - FIFO emptied, scoreboard cleared.
  - issue_valid <= 0, issue_inst <= 0.
  - A simultaneous accept is dropped, but an illegal pulse still fires.
  - flush has priority over halt.
- halt: scoreboard keeps shifting; FIFO still accepts.
- FSM states:
  - IDLE: FIFO empty and scoreboard empty.
  - ISSUE: last edge issued.
  - STALL: FIFO non-empty, blocked by a hazard.
  - HALT: halt high.
- FSM transitions, evaluated each edge with priority flush > halt > issue > stall:
  - flush → IDLE.
  - halt → HALT.
  - issued → ISSUE.
  - hazard → STALL.
  - otherwise → IDLE if the scoreboard is empty, else remain.
- Reset mid-operation discards everything; there are no partial issues.

Decomposition:
- Shared package `proc_isa_pkg`:
  - opcode constants OP_ADDSUB=7'h01, OP_SHIFT=7'h03, OP_SLT=7'h07, OP_LOGIC=7'h0f.
  - field bit ranges.
  - NOP=32'h0.
  - FSM state encoding.
- One sub-module, `inst_fifo` (DEPTH-parameterised, synchronous, count output). Legality check, scoreboard and FSM stay in inst_issue_ctrl.

Test Plan:
- Independent stream: push ADD x7=x1+x2 (32'h00208381) then XOR x14=x1^x2 (32'h0020870f) on consecutive cycles → issued on consecutive cycles, issue_valid high 2 cycles, busy high.
- RAW hazard: 32'h00208381 then SUB x8=x7-x1 (32'h00139401), WB_LATENCY=2 → SUB issued exactly 3 cycles after ADD, with two issue_inst=0 cycles between; state STALL during the gap.
- rd=0 exemption: writer with rd=0 followed by a reader of x0 → no bubble.
- Illegal: opcode 7'h05, and opcode 7'h03 with funct3=3 → illegal pulses 1 cycle each, count unchanged, nothing issued.
- Full/backpressure: halt=1, push 5 legal instructions → in_ready drops after the 4th, count=4. Release halt → 4 issued in order.
- Flush and reset: with count=3, assert flush for 1 cycle → count=0, issue_valid=0 next cycle, state IDLE. Repeat with reset_n low → all outputs 0 and in_ready=0 during reset.

Source files
------------

// File: rtl/proc_isa_pkg.sv
// Instruction field layout, opcode constants, NOP encoding and issue FSM states.
package proc_isa_pkg;

    localparam logic [6:0] OP_ADDSUB = 7'h01;
    localparam logic [6:0] OP_SHIFT  = 7'h03;
    localparam logic [6:0] OP_SLT    = 7'h07;
    localparam logic [6:0] OP_LOGIC  = 7'h0f;

    localparam int OPC_LSB = 0;
    localparam int OPC_MSB = 6;
    localparam int RD_LSB  = 7;
    localparam int RD_MSB  = 11;
    localparam int F3_LSB  = 12;
    localparam int F3_MSB  = 14;
    localparam int RS1_LSB = 15;
    localparam int RS1_MSB = 19;
    localparam int RS2_LSB = 20;
    localparam int RS2_MSB = 24;
    localparam int F7_LSB  = 25;
    localparam int F7_MSB  = 31;

    localparam logic [31:0] NOP = 32'h0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_STALL = 2'd2,
        ST_HALT  = 2'd3
    } issue_state_t;

    // funct7 plays no part in legality
    function automatic logic is_legal(input logic [6:0] op, input logic [2:0] f3);
        case (op)
            OP_ADDSUB: return (f3 <= 3'd1);
            OP_SHIFT:  return (f3 <= 3'd2);
            OP_SLT:    return (f3 <= 3'd1);
            OP_LOGIC:  return (f3 <= 3'd2);
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/inst_fifo.sv
// Synchronous FIFO with occupancy count; head entry is visible combinationally.
module inst_fifo #(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Storage array; contents need no reset since count gates visibility
    always_ff @(posedge clock) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clock) begin
        if (!reset_n || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/inst_issue_ctrl.sv
// Issue controller: legality filter, buffering FIFO, RAW scoreboard and issue FSM.
module inst_issue_ctrl
    import proc_isa_pkg::*;
#(
    parameter  int unsigned DEPTH      = 4,
    parameter  int unsigned WB_LATENCY = 2,
    localparam int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [31:0]      in_inst,
    output logic             in_ready,
    input  logic             halt,
    input  logic             flush,
    output logic [31:0]      issue_inst,
    output logic             issue_valid,
    output logic             illegal,
    output logic [CNT_W-1:0] count,
    output logic             busy
);

    logic [31:0]           head;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  legal;
    logic                  accept;
    logic                  push;
    logic                  hazard;
    logic                  do_issue;
    logic                  sb_empty;
    logic [WB_LATENCY-1:0] sb_v;
    logic [4:0]            sb_rd [WB_LATENCY];
    issue_state_t          state;
    issue_state_t          state_nxt;

    assign in_ready = reset_n & ~fifo_full;
    assign legal    = is_legal(in_inst[OPC_MSB:OPC_LSB], in_inst[F3_MSB:F3_LSB]);
    assign accept   = in_valid & in_ready;
    assign push     = accept & legal & ~flush;
    assign do_issue = ~fifo_empty & ~hazard & ~halt & ~flush;
    assign sb_empty = ~|sb_v;
    assign busy     = (state != ST_IDLE);

    inst_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (flush),
        .push    (push),
        .din     (in_inst),
        .pop     (do_issue),
        .dout    (head),
        .count   (count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    // Head depends on an in-flight writer (x0 never creates a dependency)
    always_comb begin
        hazard = 1'b0;
        for (int unsigned i = 0; i < WB_LATENCY; i++) begin
            if (sb_v[i] && (sb_rd[i] != '0) &&
                ((sb_rd[i] == head[RS1_MSB:RS1_LSB]) || (sb_rd[i] == head[RS2_MSB:RS2_LSB])))
                hazard = 1'b1;
        end
        hazard = hazard & ~fifo_empty;
    end

    // Scoreboard shift register: slot 0 records this edge's issue, oldest drops off
    always_ff @(posedge clock) begin
        if (!reset_n || flush) begin
            sb_v <= '0;
            for (int unsigned i = 0; i < WB_LATENCY; i++)
                sb_rd[i] <= '0;
        end else begin
            for (int unsigned i = 1; i < WB_LATENCY; i++) begin
                sb_v[i]  <= sb_v[i-1];
                sb_rd[i] <= sb_rd[i-1];
            end
            sb_v[0]  <= do_issue;
            sb_rd[0] <= head[RD_MSB:RD_LSB];
        end
    end

    // Registered issue outputs and illegal pulse (illegal still fires under flush)
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            issue_inst  <= NOP;
            issue_valid <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            issue_inst  <= do_issue ? head : NOP;
            issue_valid <= do_issue;
            illegal     <= accept & ~legal;
        end
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (!reset_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next state, priority flush > halt > issue > stall
    always_comb begin
        state_nxt = state;
        if (flush)
            state_nxt = ST_IDLE;
        else if (halt)
            state_nxt = ST_HALT;
        else if (do_issue)
            state_nxt = ST_ISSUE;
        else if (hazard)
            state_nxt = ST_STALL;
        else if (sb_empty)
            state_nxt = ST_IDLE;
    end

endmodule
